// File: rtl/wb_scoreboard.sv
// Register/status-flag hazard scoreboard: counts issued-but-unretired writes
// per register and for the status flags, and raises the decode stall.
module wb_scoreboard #(
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned FLUSH_MASK   = 3,
    localparam int unsigned IDX_W       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_wb_en,
    input  logic [IDX_W-1:0]    issue_dest,
    input  logic                issue_s,
    input  logic                use_src1,
    input  logic [IDX_W-1:0]    src1,
    input  logic                two_src,
    input  logic [IDX_W-1:0]    src2,
    input  logic                use_sr,
    input  logic                wb_en,
    input  logic [IDX_W-1:0]    wb_dest,
    input  logic                sr_update,
    input  logic                flush,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                sr_pending,
    output logic                underflow_err
);

    localparam int unsigned MASK_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [MASK_W-1:0] MASK_LD = MASK_W'(FLUSH_MASK);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [CNT_W-1:0]    sr_cnt_q, sr_cnt_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                err_q, err_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                sr_pend_q, sr_pend_d;
    logic [NUM_REGS-1:0] inc_vec, dec_vec;
    logic                fire;
    logic                sr_inc, sr_dec;

    // Stall uses registered counters only; same-cycle retirement releases next cycle.
    always_comb begin
        hazard = issue_valid & (
                   (use_src1    & (cnt_q[src1] != '0))
                 | (two_src     & (cnt_q[src2] != '0))
                 | (use_sr      & (sr_cnt_q != '0))
                 | (issue_wb_en & (cnt_q[issue_dest] == CNT_MAX))
                 | (issue_s     & (sr_cnt_q == CNT_MAX)));
        fire   = issue_valid & ~hazard & ~flush;
        sr_inc = fire & issue_s;
        sr_dec = sr_update;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = fire & issue_wb_en & (issue_dest == IDX_W'(i));
            dec_vec[i] = wb_en & (wb_dest == IDX_W'(i));
        end
    end

    always_comb begin
        logic uflow;
        cnt_d    = cnt_q;
        sr_cnt_d = sr_cnt_q;
        mask_d   = mask_q;
        err_d    = err_q;
        uflow    = 1'b0;
        if (flush) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_d[i] = '0;
            sr_cnt_d = '0;
            mask_d   = MASK_LD;
        end else begin
            if (mask_q != '0) mask_d = mask_q - MASK_W'(1);
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end else if (!inc_vec[i] && dec_vec[i]) begin
                    if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
                    else                uflow    = 1'b1;
                end
            end
            if (sr_inc && !sr_dec) begin
                sr_cnt_d = sr_cnt_q + CNT_ONE;
            end else if (!sr_inc && sr_dec) begin
                if (sr_cnt_q != '0) sr_cnt_d = sr_cnt_q - CNT_ONE;
                else                uflow    = 1'b1;
            end
            // Retirements of squashed work are expected right after a flush.
            if (uflow && (mask_q == '0)) err_d = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REGS; i++) busy_d[i] = (cnt_d[i] != '0);
        sr_pend_d = (sr_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
            sr_cnt_q  <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= '0;
            sr_pend_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
            sr_cnt_q  <= sr_cnt_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            sr_pend_q <= sr_pend_d;
        end
    end

    assign busy_vec      = busy_q;
    assign sr_pending    = sr_pend_q;
    assign underflow_err = err_q;

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Register-hazard scoreboard; produces the `hazard` stall input consumed by the decode stage.
- Tracks register destinations and status-flag updates issued from decode but not yet retired.
- Retirement comes from the write-back side (wb_en, wb_dest) and from the execute-stage status-register update strobe.
- Sits beside decode; closes the loop between instruction issue and write-back.

Parameters:
NUM_REGS, 16, architectural registers tracked (index width 4)
CNT_W, 2, width of each per-register in-flight counter
MAX_INFLIGHT, 3, saturation value of a counter; must be <= 2**CNT_W-1
FLUSH_MASK, 3, cycles after flush during which underflowing retirements are silently ignored

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
issue_valid  in  1  decode presents an instruction this cycle
issue_wb_en  in  1  issued instruction writes a register
issue_dest  in  4  destination register of issued instruction
issue_s  in  1  issued instruction updates status flags
use_src1  in  1  instruction reads src1
src1  in  4  first source register
two_src  in  1  instruction reads src2
src2  in  4  second source register
use_sr  in  1  instruction condition is not AL (reads flags)
wb_en  in  1  write-back retires a register write this cycle
wb_dest  in  4  register retired by write-back
sr_update  in  1  execute stage wrote the status register this cycle
flush  in  1  pipeline squash (taken branch)
hazard  out  1  stall decode; combinational from registered state and current decode inputs
busy_vec  out  16  bit i = counter i nonzero (registered)
sr_pending  out  1  status-flag writes outstanding (registered)
underflow_err  out  1  sticky: retirement seen with counter zero outside the flush mask window

Behaviour:
- State: cnt[0..15] (CNT_W bits each), sr_cnt (CNT_W bits), mask_cnt (2 bits), underflow_err.
- Reset (rst=0, async): all counters 0, mask_cnt 0, underflow_err 0. Hence hazard=0 when issue_valid=0, busy_vec=0, sr_pending=0.
- hazard = issue_valid & ( (use_src1 & cnt[src1]!=0) | (two_src & cnt[src2]!=0) | (use_sr & sr_cnt!=0) | (issue_wb_en & cnt[issue_dest]==MAX_INFLIGHT) | (issue_s & sr_cnt==MAX_INFLIGHT) ).
- hazard reads registered counters only. A same-cycle wb_en to a source register does not clear hazard; the stall releases the next cycle.
- fire = issue_valid & ~hazard & ~flush.
- Per-register update at posedge: inc = fire & issue_wb_en & issue_dest==i; dec = wb_en & wb_dest==i.
  - inc & dec: no change.
  - inc only: +1.
  - dec only: -1 if nonzero. If zero, hold 0 and set underflow_err when mask_cnt==0.
- sr_cnt follows the same rules with inc = fire & issue_s and dec = sr_update.
- flush has priority over issue and retirement: all counters and sr_cnt go to 0; mask_cnt loads FLUSH_MASK.
- mask_cnt decrements to 0 each non-flush cycle. While mask_cnt!=0, underflowing retirements are ignored without an error.
- underflow_err clears only on reset.
- No internal FSM beyond the counters and the mask_cnt countdown.
- Latency: issue at edge N makes busy_vec/hazard visible from cycle N+1; retirement at edge M clears from cycle M+1.

Test Plan:
1. Reset, then idle -> hazard=0, busy_vec=16'h0000, sr_pending=0, underflow_err=0.
2. Issue wb_en dest=R3; next cycle src1=R3, use_src1=1 -> hazard=1, busy_vec=16'h0008. Drive wb_en wb_dest=3 that cycle -> hazard still 1; following cycle hazard=0, busy_vec=0.
3. Three back-to-back issues dest=R5 with no retirement -> cnt[5]=3. Fourth issue dest=R5 (no source use) -> hazard=1. One wb_dest=5 -> cnt=2; issue accepted next cycle.
4. Same-cycle fire dest=R7 and wb_en wb_dest=7 with cnt[7]=1 -> cnt[7] stays 1, busy_vec[7]=1.
5. issue_s=1 fires; next cycle use_sr=1 -> hazard=1, sr_pending=1. sr_update pulse -> sr_pending=0 one cycle later, hazard=0.
6. Two pending regs, then flush -> busy_vec=0. Retirements to those regs within 3 cycles -> underflow_err=0. Retirement to a zero counter at cycle 4 after flush -> underflow_err=1 and stays 1.
